// File: rtl/kyber_pattern_sequencer.sv
// Walks the Kyber patt/eta3/endp masks MSB-first, one bit per unstalled cycle,
// and emits the per-step strobes for the CBD sampler / packer datapath.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start; masks captured on the accepting edge
// S_RUN  | one mask bit consumed per cycle with stall low
// S_DONE | single-cycle done pulse, then back to idle
module kyber_pattern_sequencer #(
   parameter int W  = 73,
   parameter int CW = 7
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stall,
   input  logic [W-1:0]  patt_i,
   input  logic [W-1:0]  eta3_i,
   input  logic [W-1:0]  endp_i,
   output logic          busy,
   output logic          fire,
   output logic          eta3_fire,
   output logic          last,
   output logic          done,
   output logic          err,
   output logic [CW-1:0] step_idx,
   output logic [CW-1:0] fire_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST_IDX = CW'(W - 1);

   state_t        state_q;
   logic [W-1:0]  patt_sr_q;
   logic [W-1:0]  eta3_sr_q;
   logic [W-1:0]  endp_sr_q;
   logic [CW-1:0] step_idx_q;
   logic [CW-1:0] fire_cnt_q;
   logic          err_q;

   logic adv;
   logic at_last_idx;

   assign adv         = (state_q == S_RUN) & ~stall;
   assign at_last_idx = (step_idx_q == LAST_IDX);

   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);
   assign fire      = adv & patt_sr_q[W-1];
   assign eta3_fire = adv & eta3_sr_q[W-1];
   assign last      = adv & (endp_sr_q[W-1] | at_last_idx);
   assign err       = err_q;
   assign step_idx  = step_idx_q;
   assign fire_cnt  = fire_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         patt_sr_q  <= '0;
         eta3_sr_q  <= '0;
         endp_sr_q  <= '0;
         step_idx_q <= '0;
         fire_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  patt_sr_q  <= patt_i;
                  eta3_sr_q  <= eta3_i;
                  endp_sr_q  <= endp_i;
                  step_idx_q <= '0;
                  fire_cnt_q <= '0;
                  err_q      <= 1'b0;
                  state_q    <= S_RUN;
               end
            end
            S_RUN: begin
               if (adv) begin
                  patt_sr_q  <= {patt_sr_q[W-2:0], 1'b0};
                  eta3_sr_q  <= {eta3_sr_q[W-2:0], 1'b0};
                  endp_sr_q  <= {endp_sr_q[W-2:0], 1'b0};
                  step_idx_q <= step_idx_q + CW'(1);
                  if (patt_sr_q[W-1]) begin
                     fire_cnt_q <= fire_cnt_q + CW'(1);
                  end
                  // An endp bit on the final index is a clean finish, not an error.
                  if (endp_sr_q[W-1]) begin
                     state_q <= S_DONE;
                  end else if (at_last_idx) begin
                     err_q   <= 1'b1;
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_kyber_pattern_sequencer.sv
// Scoreboard bench for kyber_pattern_sequencer: stimulus queues expected
// step/done records, a negedge monitor pops and compares them.
module tb_kyber_pattern_sequencer;

   localparam int W  = 73;
   localparam int CW = 7;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic          stall;
   logic [W-1:0]  patt_i;
   logic [W-1:0]  eta3_i;
   logic [W-1:0]  endp_i;
   logic          busy;
   logic          fire;
   logic          eta3_fire;
   logic          last;
   logic          done;
   logic          err;
   logic [CW-1:0] step_idx;
   logic [CW-1:0] fire_cnt;

   kyber_pattern_sequencer #(.W(W), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .stall     (stall),
      .patt_i    (patt_i),
      .eta3_i    (eta3_i),
      .endp_i    (endp_i),
      .busy      (busy),
      .fire      (fire),
      .eta3_fire (eta3_fire),
      .last      (last),
      .done      (done),
      .err       (err),
      .step_idx  (step_idx),
      .fire_cnt  (fire_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit is_done;
      int step;
      bit f;
      bit e;
      bit l;
      int fcnt;
      bit er;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unexpected DUT activity, expected none (t=%0t step_idx=%0d)",
               name, $time, step_idx);
   endtask

   always @(negedge clk) begin
      exp_t r;
      if (done) begin
         if (sb.size() == 0 || !sb[0].is_done) begin
            flag("unexpected_done");
         end else begin
            r = sb.pop_front();
            chk("done_fire_cnt", fire_cnt, r.fcnt);
            chk("done_err", err, r.er);
            chk("done_step_idx", step_idx, r.step);
            chk("done_cycle", cyc, r.cyc);
            chk("done_strobes_low", {fire, eta3_fire, last}, 0);
         end
      end else if (busy && stall) begin
         if (sb.size() == 0 || sb[0].is_done) begin
            flag("unexpected_stall_cycle");
         end else begin
            chk("stall_step_frozen", step_idx, sb[0].step);
            chk("stall_strobes_low", {fire, eta3_fire, last}, 0);
         end
      end else if (busy) begin
         if (sb.size() == 0 || sb[0].is_done) begin
            flag("unexpected_step");
         end else begin
            r = sb.pop_front();
            chk("step_idx", step_idx, r.step);
            chk("fire", fire, r.f);
            chk("eta3_fire", eta3_fire, r.e);
            chk("last", last, r.l);
         end
      end else if (fire | eta3_fire | last | done) begin
         flag("idle_strobe");
      end
   end

   task automatic run_seq(input logic [W-1:0] p, input logic [W-1:0] e, input logic [W-1:0] d,
                          input int stall_at, input int stall_len, input int restart_at,
                          input int abort_at, input int exp_fc, input bit exp_err);
      int   n;
      bit   found;
      int   j;
      exp_t r;
      n = W;
      found = 1'b0;
      for (int s = 0; s < W; s++) begin
         if (!found && d[W-1-s]) begin
            n = s + 1;
            found = 1'b1;
         end
      end
      for (int s = 0; s < n; s++) begin
         r = '{is_done: 1'b0, step: s, f: p[W-1-s], e: e[W-1-s], l: (s == n - 1),
               fcnt: 0, er: 1'b0, cyc: 0};
         sb.push_back(r);
      end
      r = '{is_done: 1'b1, step: n, f: 1'b0, e: 1'b0, l: 1'b0,
            fcnt: exp_fc, er: exp_err, cyc: cyc + n + 1 + stall_len};
      sb.push_back(r);

      patt_i = p;
      eta3_i = e;
      endp_i = d;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("start_err_cleared", err, 0);
      chk("start_busy", busy, 1);

      j = 0;
      while (sb.size() != 0 && j < 400) begin
         if (j == abort_at) begin
            rst_n = 1'b0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_strobes", {fire, eta3_fire, last, done}, 0);
            chk("abort_err", err, 0);
            chk("abort_step_idx", step_idx, 0);
            chk("abort_fire_cnt", fire_cnt, 0);
            sb.delete();
            repeat (2) @(posedge clk);
            #2;
            rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #1;
            return;
         end
         stall = (stall_at >= 0 && j >= stall_at && j < stall_at + stall_len);
         start = (j == restart_at);
         if (j == restart_at) begin
            patt_i = ~p;
            eta3_i = ~e;
            endp_i = '0;
         end
         @(posedge clk);
         #1;
         j++;
      end
      start = 1'b0;
      stall = 1'b0;
      if (sb.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL seq_timeout: got %0d records pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   logic [W-1:0] patt_k2, eta_k2, endp_k2;
   logic [W-1:0] patt_k4, eta_k4, endp_k4;
   logic [W-1:0] patt_k3, eta_k3, endp_k3;

   initial begin
      patt_k2 = {{4{6'b100000}}, 49'b0};
      eta_k2  = {{4{6'b110000}}, 49'b0};
      endp_k2 = {24'b1, 49'b0};
      patt_k4 = {{10{7'b1000000}}, 3'b000};
      eta_k4  = {{10{7'b0110000}}, 3'b101};
      endp_k4 = {72'b0, 1'b1};
      patt_k3 = {{6{6'b100000}}, 37'b0};
      eta_k3  = {{6{6'b110000}}, 37'b0};
      endp_k3 = {36'b1, 37'b0};

      rst_n  = 1'b0;
      start  = 1'b0;
      stall  = 1'b0;
      patt_i = '0;
      eta3_i = '0;
      endp_i = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_busy", busy, 0);
      chk("reset_strobes", {fire, eta3_fire, last, done}, 0);
      chk("reset_err", err, 0);
      chk("reset_step_idx", step_idx, 0);
      chk("reset_fire_cnt", fire_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // k=2 sel=0: 24 steps, four groups, done 25 cycles after start
      run_seq(patt_k2, eta_k2, endp_k2, -1, 0, -1, -1, 4, 1'b0);
      // k=4 sel=1: endp on bit 0 coincides with the final index
      run_seq(patt_k4, eta_k4, endp_k4, -1, 0, -1, -1, 10, 1'b0);
      // k=3 with a 5-cycle stall at step 10
      run_seq(patt_k3, eta_k3, endp_k3, 10, 5, -1, -1, 6, 1'b0);
      // no endp bit at all: 73 steps then sticky err
      run_seq(patt_k2, eta_k2, '0, -1, 0, -1, -1, 4, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      chk("err_sticky", err, 1);
      chk("err_sticky_idle", busy, 0);
      // restart pulse plus input changes at step 5 must be ignored
      run_seq(patt_k2, eta_k2, endp_k2, -1, 0, 5, -1, 4, 1'b0);
      // async abort at step 12, then a clean k=3 run
      run_seq(patt_k3, eta_k3, endp_k3, -1, 0, -1, 12, 6, 1'b0);
      chk("post_abort_idle", busy, 0);
      run_seq(patt_k3, eta_k3, endp_k3, -1, 0, -1, -1, 6, 1'b0);

      repeat (2) @(posedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
